// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction opcodes and program-memory FSM state encodings.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] JMP       = 4'h0;
    localparam logic [OPC_W-1:0] JNZ       = 4'h1;
    localparam logic [OPC_W-1:0] ZNJ       = 4'h2;
    localparam logic [OPC_W-1:0] ADD       = 4'h3;
    localparam logic [OPC_W-1:0] LI        = 4'h4;
    localparam logic [OPC_W-1:0] CHECK     = 4'h5;
    localparam logic [OPC_W-1:0] REFERENCE = 4'h6;
    localparam logic [OPC_W-1:0] STORE     = 4'h7;
    localparam logic [OPC_W-1:0] RTX90     = 4'h8;
    localparam logic [OPC_W-1:0] RTX180    = 4'h9;
    localparam logic [OPC_W-1:0] RTY90     = 4'hA;
    localparam logic [OPC_W-1:0] RTY180    = 4'hB;
    localparam logic [OPC_W-1:0] RTZ90     = 4'hC;
    localparam logic [OPC_W-1:0] RTZ180    = 4'hD;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Instruction storage: one synchronous write port, one registered read port, no reset.
module imem_ram_1r1w #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2**ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Read data only changes on an enabled read, so it holds between fetches.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/prog_imem.sv
// Program instruction memory: sequential loader FSM, length counter and fetch qualification.
module prog_imem
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2**ADDR_W,
    parameter int unsigned INSN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_valid,
    output logic [INSN_W-1:0] fetch_op,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [INSN_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [ADDR_W:0]   prog_len,
    output logic [1:0]        state_o,
    output logic              ld_ovf
);

    localparam int unsigned     LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    imem_state_t       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ovf_q, ovf_d;
    logic              wr_en;
    logic              fetch_ok;
    logic              zero_q;
    logic [INSN_W-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Loader: ld_start wins over everything, then sequential writes until last word or overflow.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        ld_ready = 1'b0;
        if (ld_start) begin
            state_d = ST_LOAD;
            len_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_LOAD) begin
            ld_ready = (len_q < DEPTH_L);
            if (ld_valid) begin
                if (ld_ready) begin
                    wr_en = 1'b1;
                    len_d = len_q + LEN_W'(1);
                    if (ld_last) begin
                        state_d = ST_READY;
                    end
                end else begin
                    ovf_d   = 1'b1;
                    state_d = ST_READY;
                end
            end
        end
    end

    assign fetch_ok = (state_q == ST_READY) && ({1'b0, fetch_pc} < len_q);

    // zero_q masks the RAM read register after a rejected fetch or reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                fetch_err <= !fetch_ok;
                zero_q    <= !fetch_ok;
            end
        end
    end

    assign fetch_op = zero_q ? '0 : rd_data;
    assign prog_len = len_q;
    assign state_o  = state_q;
    assign ld_ovf   = ovf_q;

    imem_ram_1r1w #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (INSN_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (len_q[ADDR_W-1:0]),
        .wdata (ld_data),
        .re    (fetch_req && fetch_ok),
        .raddr (fetch_pc),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_prog_imem.sv
// Self-checking bench for prog_imem (DEPTH=4): fetch scoreboard plus per-scenario inline checks.
module tb_prog_imem;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned INSN_W = 32;

    typedef struct packed {
        logic              err;
        logic [INSN_W-1:0] op;
    } fexp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_valid;
    logic [INSN_W-1:0] fetch_op;
    logic              fetch_err;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [INSN_W-1:0] ld_data;
    logic              ld_last;
    logic [ADDR_W:0]   prog_len;
    logic [1:0]        state_o;
    logic              ld_ovf;

    fexp_t             exp_q[$];
    int                n_assert = 0;
    int                n_fail   = 0;
    logic [INSN_W-1:0] last_op  = '0;
    logic [INSN_W-1:0] first_word;

    prog_imem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .INSN_W (INSN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_op    (fetch_op),
        .fetch_err   (fetch_err),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .prog_len    (prog_len),
        .state_o     (state_o),
        .ld_ovf      (ld_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation per accepted fetch; otherwise fetch_op must hold its last value.
    task automatic scoreboard_monitor();
        logic  pend;
        logic  rstd;
        fexp_t e;
        forever begin
            @(posedge clk);
            pend = fetch_req && rst_n;
            rstd = !rst_n;
            @(negedge clk);
            if (rstd) last_op = '0;
            n_assert++;
            if (fetch_valid !== pend) begin
                n_fail++;
                $display("FAIL fetch_valid: got %b expected %b at %0t", fetch_valid, pend, $time);
            end
            if (pend) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: got a fetch with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (fetch_err !== e.err || fetch_op !== e.op) begin
                        n_fail++;
                        $display("FAIL fetch_data: got err=%b op=%h expected err=%b op=%h at %0t",
                                 fetch_err, fetch_op, e.err, e.op, $time);
                    end
                    last_op = e.op;
                end
            end else begin
                n_assert++;
                if (fetch_op !== last_op) begin
                    n_fail++;
                    $display("FAIL fetch_op_hold: got %h expected %h at %0t", fetch_op, last_op, $time);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_assert++;
        if (state_o !== 2'd0 || prog_len !== '0 || ld_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got state=%0d len=%0d ovf=%b expected 0 0 0", state_o, prog_len, ld_ovf);
        end
        n_assert++;
        if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_op !== '0) begin
            n_fail++;
            $display("FAIL reset_fetch: got valid=%b err=%b op=%h expected 0 0 0", fetch_valid, fetch_err, fetch_op);
        end
        fetch_req = 1'b1;
        fetch_pc  = '0;
        exp_q.push_back(fexp_t'{err: 1'b1, op: '0});
        tick();
        fetch_req = 1'b0;
        n_assert++;
        if (state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL empty_state: got %0d expected 0", state_o);
        end
        tick();
    endtask

    task automatic test_load_and_fetch();
        logic [INSN_W-1:0] w [3];
        w = '{32'h6860_0000, 32'hB0D0_0000, 32'hB3D0_0000};
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        n_assert++;
        if (state_o !== 2'd1 || prog_len !== '0) begin
            n_fail++;
            $display("FAIL load_entry: got state=%0d len=%0d expected 1 0", state_o, prog_len);
        end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = w[i];
            ld_last  = (i == 2);
            #1;
            n_assert++;
            if (ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready: got %b expected 1 word %0d", ld_ready, i);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_assert++;
        if (prog_len !== 9'd3 || state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL load_done: got len=%0d state=%0d expected 3 2", prog_len, state_o);
        end
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1;
            fetch_pc  = ADDR_W'(i);
            if (i < 3) exp_q.push_back(fexp_t'{err: 1'b0, op: w[i]});
            else       exp_q.push_back(fexp_t'{err: 1'b1, op: '0});
            tick();
        end
        fetch_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA5A5_0000 + 32'(i);
            ld_last  = 1'b0;
            #1;
            n_assert++;
            if (ld_ready !== (i < 4)) begin
                n_fail++;
                $display("FAIL ovf_ready: got %b expected %b word %0d", ld_ready, (i < 4), i);
            end
            tick();
            if (i == 3) begin
                n_assert++;
                if (prog_len !== 9'd4 || state_o !== 2'd1 || ld_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_load: got len=%0d state=%0d ovf=%b expected 4 1 0", prog_len, state_o, ld_ovf);
                end
            end
        end
        ld_valid = 1'b0;
        n_assert++;
        if (prog_len !== 9'd4 || state_o !== 2'd2 || ld_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got len=%0d state=%0d ovf=%b expected 4 2 1", prog_len, state_o, ld_ovf);
        end
        for (int i = 0; i < 6; i++) begin
            fetch_req = 1'b1;
            fetch_pc  = (i == 5) ? 8'hFF : ADDR_W'(i);
            if (i < 4) exp_q.push_back(fexp_t'{err: 1'b0, op: 32'hA5A5_0000 + 32'(i)});
            else       exp_q.push_back(fexp_t'{err: 1'b1, op: '0});
            tick();
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_random_load();
        logic [INSN_W-1:0] words[$];
        int cnt    = 0;
        int cycles = 0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        n_assert++;
        if (ld_ovf !== 1'b0 || prog_len !== '0) begin
            n_fail++;
            $display("FAIL restart_clear: got ovf=%b len=%0d expected 0 0", ld_ovf, prog_len);
        end
        while (cnt < 4 && cycles < 200) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = $urandom;
            ld_last  = (cnt == 3);
            #1;
            n_assert++;
            if (ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_ready: got %b expected 1 cycle %0d", ld_ready, cycles);
            end
            if (ld_valid) begin
                words.push_back(ld_data);
                cnt++;
            end
            tick();
            cycles++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_assert++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL rnd_timeout: got %0d words expected 4", cnt);
        end
        n_assert++;
        if (prog_len !== 9'(cnt) || state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL rnd_done: got len=%0d state=%0d expected %0d 2", prog_len, state_o, cnt);
        end
        for (int i = 0; i < cnt; i++) begin
            fetch_req = 1'b1;
            fetch_pc  = ADDR_W'(i);
            exp_q.push_back(fexp_t'{err: 1'b0, op: words[i]});
            tick();
        end
        fetch_req  = 1'b0;
        first_word = (cnt > 0) ? words[0] : '0;
        tick();
    endtask

    task automatic test_start_with_fetch();
        ld_start  = 1'b1;
        ld_valid  = 1'b1;
        ld_data   = 32'hDEAD_BEEF;
        ld_last   = 1'b1;
        fetch_req = 1'b1;
        fetch_pc  = '0;
        exp_q.push_back(fexp_t'{err: 1'b0, op: first_word});
        #1;
        n_assert++;
        if (ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ready: got %b expected 0", ld_ready);
        end
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        exp_q.push_back(fexp_t'{err: 1'b1, op: '0});
        n_assert++;
        if (state_o !== 2'd1 || prog_len !== '0) begin
            n_fail++;
            $display("FAIL start_ignore_valid: got state=%0d len=%0d expected 1 0", state_o, prog_len);
        end
        tick();
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_during_load();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h4000_0000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        n_assert++;
        if (prog_len !== 9'd2) begin
            n_fail++;
            $display("FAIL partial_load: got len=%0d expected 2", prog_len);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_assert++;
        if (state_o !== 2'd0 || prog_len !== '0) begin
            n_fail++;
            $display("FAIL mid_load_reset: got state=%0d len=%0d expected 0 0", state_o, prog_len);
        end
        fetch_req = 1'b1;
        fetch_pc  = '0;
        exp_q.push_back(fexp_t'{err: 1'b1, op: '0});
        ld_valid  = 1'b1;
        ld_last   = 1'b1;
        #1;
        n_assert++;
        if (ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_ready: got %b expected 0", ld_ready);
        end
        tick();
        fetch_req = 1'b0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        n_assert++;
        if (state_o !== 2'd0 || prog_len !== '0) begin
            n_fail++;
            $display("FAIL empty_no_load: got state=%0d len=%0d expected 0 0", state_o, prog_len);
        end
        tick();
    endtask

    task automatic test_reload();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = {LI, 28'h0000123};
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_assert++;
        if (state_o !== 2'd2 || prog_len !== 9'd1) begin
            n_fail++;
            $display("FAIL reload: got state=%0d len=%0d expected 2 1", state_o, prog_len);
        end
        fetch_req = 1'b1;
        fetch_pc  = 8'd1;
        exp_q.push_back(fexp_t'{err: 1'b1, op: '0});
        tick();
        fetch_pc = 8'd0;
        exp_q.push_back(fexp_t'{err: 1'b0, op: {LI, 28'h0000123}});
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        fetch_pc  = '0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_load_and_fetch();
        test_overflow();
        test_random_load();
        test_start_with_fetch();
        test_reset_during_load();
        test_reload();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
